// File: rtl/spi_slave_regfile.sv
// SPI slave with an addressed register file, clocked directly by sclk (mode: sample/drive on posedge).
// Optional per-word even parity slot and sticky par_err flag when SPI_SLAVE_PARITY_EN is defined.
module spi_slave_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              sclk,
  input  logic              i_reset_n,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_valid,
  output logic              busy,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [DATA_W-1:0] loc_data,
`ifdef SPI_SLAVE_PARITY_EN
  output logic              par_err,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int MAXW  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_PAR  = 2'd3
  } state_e;

  state_e              state_q;
  logic                rw_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   shreg_q;
  logic                miso_q;
  logic [DATA_W-1:0]   dout_q;
  logic [ADDR_W-1:0]   dout_addr_q;
  logic                dout_valid_q;
  logic [DATA_W-1:0]   regs_q [DEPTH];
`ifdef SPI_SLAVE_PARITY_EN
  logic                par_err_q;
`endif

  logic [ADDR_W-1:0]   addr_shift_d;
  logic [ADDR_W-1:0]   addr_inc_d;
  logic [DATA_W-1:0]   wr_word_d;
  logic [CNT_W-1:0]    rd_idx_d;
  logic                rd_bit_d;

  always_comb begin
    addr_shift_d = (addr_q << 1) | ADDR_W'(mosi);
    addr_inc_d   = addr_q + ADDR_W'(1);
    wr_word_d    = (shreg_q >> 1) | (DATA_W'(mosi) << (DATA_W - 1));
    rd_idx_d     = bit_cnt_q + CNT_W'(1);
    rd_bit_d     = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (rd_idx_d == CNT_W'(i)) rd_bit_d = shreg_q[i];
    end
  end

  // Read data is one edge ahead of the master: the bit driven on edge k is sampled on edge k+1.
  always_ff @(posedge sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      rw_q         <= 1'b0;
      bit_cnt_q    <= '0;
      addr_q       <= '0;
      shreg_q      <= '0;
      miso_q       <= 1'b0;
      dout_q       <= '0;
      dout_addr_q  <= '0;
      dout_valid_q <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      par_err_q    <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      dout_valid_q <= 1'b0;
      if (cs) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            rw_q      <= mosi;
            bit_cnt_q <= '0;
            state_q   <= ST_ADDR;
          end
          ST_ADDR: begin
            addr_q <= addr_shift_d;
            if (bit_cnt_q == ADDR_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= ST_DATA;
              if (rw_q) begin
                shreg_q <= regs_q[addr_shift_d];
                miso_q  <= regs_q[addr_shift_d][0];
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          ST_DATA: begin
            if (!rw_q) shreg_q <= wr_word_d;
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
`ifdef SPI_SLAVE_PARITY_EN
              state_q <= ST_PAR;
              if (rw_q) miso_q <= ^shreg_q;
`else
              addr_q <= addr_inc_d;
              if (rw_q) begin
                shreg_q <= regs_q[addr_inc_d];
                miso_q  <= regs_q[addr_inc_d][0];
              end else begin
                regs_q[addr_q] <= wr_word_d;
                dout_q         <= wr_word_d;
                dout_addr_q    <= addr_q;
                dout_valid_q   <= 1'b1;
              end
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (rw_q) miso_q <= rd_bit_d;
            end
          end
`ifdef SPI_SLAVE_PARITY_EN
          ST_PAR: begin
            state_q <= ST_DATA;
            addr_q  <= addr_inc_d;
            if (rw_q) begin
              shreg_q <= regs_q[addr_inc_d];
              miso_q  <= regs_q[addr_inc_d][0];
            end else if (mosi == ^shreg_q) begin
              regs_q[addr_q] <= shreg_q;
              dout_q         <= shreg_q;
              dout_addr_q    <= addr_q;
              dout_valid_q   <= 1'b1;
            end else begin
              par_err_q <= 1'b1;
            end
          end
`endif
          default: begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  // dout/dout_addr are qualified by dout_valid, a single-cycle pulse with no back-pressure.
  assign miso        = miso_q;
  assign dout        = dout_q;
  assign dout_addr   = dout_addr_q;
  assign dout_valid  = dout_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign loc_data    = regs_q[loc_addr];
  assign dbg_state_o = state_q;
`ifdef SPI_SLAVE_PARITY_EN
  assign par_err     = par_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: write commits and read words checked through expected queues.
module tb_spi_slave_regfile;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic              sclk      = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              cs        = 1'b1;
  logic              mosi      = 1'b0;
  logic [ADDR_W-1:0] loc_addr  = '0;
  logic              miso;
  logic [DATA_W-1:0] dout;
  logic [ADDR_W-1:0] dout_addr;
  logic              dout_valid;
  logic              busy;
  logic [DATA_W-1:0] loc_data;
  logic [1:0]        dbg_state;
`ifdef SPI_SLAVE_PARITY_EN
  logic              par_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
  logic [DATA_W-1:0]        exp_rd_q[$];
  logic [ADDR_W+DATA_W-1:0] wr_exp;
  logic [DATA_W-1:0]        rd_exp;
  logic [DATA_W-1:0]        rd_word;
  event                     rd_evt;

  always #5 sclk = ~sclk;

  spi_slave_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .sclk        (sclk),
    .i_reset_n   (i_reset_n),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .dout        (dout),
    .dout_addr   (dout_addr),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .loc_addr    (loc_addr),
    .loc_data    (loc_data),
`ifdef SPI_SLAVE_PARITY_EN
    .par_err     (par_err),
`endif
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Commit monitor: every dout_valid pulse must match the oldest expected {addr,data}.
  always @(negedge sclk) begin
    if (i_reset_n && dout_valid) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got addr=%0d data=0x%0h with nothing expected", dout_addr, dout);
      end else begin
        wr_exp = exp_wr_q.pop_front();
        check("commit", {21'd0, dout_addr, dout}, {21'd0, wr_exp});
      end
    end
  end

  // Read monitor: each word assembled from miso is compared with the oldest expected read word.
  always @(rd_evt) begin
    if (exp_rd_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_read: got 0x%0h with nothing expected", rd_word);
    end else begin
      rd_exp = exp_rd_q.pop_front();
      check("read_word", {24'd0, rd_word}, {24'd0, rd_exp});
    end
  end

  // One sclk slot: s is the miso level the master samples on the coming posedge.
  task automatic slot(input logic c, input logic m, output logic s);
    @(negedge sclk);
    s    = miso;
    cs   = c;
    mosi = m;
    @(posedge sclk);
  endtask

  task automatic start_frame(input logic rw, input logic [ADDR_W-1:0] a);
    logic s;
    slot(1'b0, rw, s);
    for (int i = ADDR_W - 1; i >= 0; i--) slot(1'b0, a[i], s);
  endtask

  task automatic xfer_word(input logic [DATA_W-1:0] w, input logic is_read);
    logic s;
    logic [DATA_W-1:0] got;
    got = '0;
    for (int j = 0; j < DATA_W; j++) begin
      slot(1'b0, w[j], s);
      got[j] = s;
    end
`ifdef SPI_SLAVE_PARITY_EN
    slot(1'b0, ^w, s);
`endif
    if (is_read) begin
      rd_word = got;
      -> rd_evt;
    end
  endtask

  task automatic end_frame();
    logic s;
    slot(1'b1, 1'b0, s);
  endtask

  task automatic check_loc(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string name);
    @(negedge sclk);
    loc_addr = a;
    #1;
    check(name, {24'd0, loc_data}, {24'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    repeat (2) @(negedge sclk);
    #1;
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_dout_addr", {29'd0, dout_addr}, 32'd0);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_loc_data", {24'd0, loc_data}, 32'd0);
`ifdef SPI_SLAVE_PARITY_EN
    check("rst_par_err", {31'd0, par_err}, 32'd0);
`endif
    i_reset_n = 1'b1;
    slot(1'b1, 1'b0, s);

    // Single write of 0xA5 to address 5
    exp_wr_q.push_back({3'd5, 8'hA5});
    start_frame(1'b0, 3'd5);
    #1;
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    xfer_word(8'hA5, 1'b0);
    end_frame();
    check_loc(3'd5, 8'hA5, "loc_after_write");

    // Read back address 5; mosi held high during data to show it is ignored
    exp_rd_q.push_back(8'hA5);
    start_frame(1'b1, 3'd5);
    xfer_word(8'hFF, 1'b1);
    end_frame();
    check_loc(3'd5, 8'hA5, "loc_after_read");

    // Burst write across the wrap: 7 then 0
    exp_wr_q.push_back({3'd7, 8'h11});
    exp_wr_q.push_back({3'd0, 8'h22});
    start_frame(1'b0, 3'd7);
    xfer_word(8'h11, 1'b0);
    xfer_word(8'h22, 1'b0);
    end_frame();
    check_loc(3'd7, 8'h11, "loc_burst_7");
    check_loc(3'd0, 8'h22, "loc_burst_0");

    // Burst read across the wrap
    exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'h22);
    start_frame(1'b1, 3'd7);
    xfer_word(8'h00, 1'b1);
    xfer_word(8'h00, 1'b1);
    end_frame();

    // Abort after 4 data bits, then a full write to the same address
    start_frame(1'b0, 3'd2);
    for (int i = 0; i < 4; i++) slot(1'b0, 1'b1, s);
    end_frame();
    #1;
    check("busy_after_abort", {31'd0, busy}, 32'd0);
    check_loc(3'd2, 8'h00, "loc_after_abort");
    exp_wr_q.push_back({3'd2, 8'h3C});
    start_frame(1'b0, 3'd2);
    xfer_word(8'h3C, 1'b0);
    end_frame();
    check_loc(3'd2, 8'h3C, "loc_after_rewrite");
    exp_rd_q.push_back(8'h3C);
    start_frame(1'b1, 3'd2);
    xfer_word(8'h00, 1'b1);
    end_frame();

    // Asynchronous reset in the middle of a burst
    exp_wr_q.push_back({3'd4, 8'h5A});
    start_frame(1'b0, 3'd4);
    xfer_word(8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) slot(1'b0, 1'b1, s);
    @(negedge sclk);
    #2;
    i_reset_n = 1'b0;
    cs        = 1'b1;
    #1;
    check("arst_dout", {24'd0, dout}, 32'd0);
    check("arst_dout_addr", {29'd0, dout_addr}, 32'd0);
    check("arst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("arst_miso", {31'd0, miso}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      loc_addr = 3'(a);
      #1;
      check("arst_regs", {24'd0, loc_data}, 32'd0);
    end
    @(negedge sclk);
    i_reset_n = 1'b1;
    slot(1'b1, 1'b0, s);
    exp_rd_q.push_back(8'h00);
    start_frame(1'b1, 3'd5);
    xfer_word(8'h00, 1'b1);
    end_frame();

`ifdef SPI_SLAVE_PARITY_EN
    // 0xA5 has even parity 0: a PAR bit of 1 drops the word and sets par_err
    start_frame(1'b0, 3'd1);
    for (int j = 0; j < DATA_W; j++) slot(1'b0, (j == 0 || j == 2 || j == 5 || j == 7), s);
    slot(1'b0, 1'b1, s);
    end_frame();
    #1;
    check("par_err_set", {31'd0, par_err}, 32'd1);
    check_loc(3'd1, 8'h00, "loc_par_dropped");
    exp_wr_q.push_back({3'd1, 8'hA5});
    start_frame(1'b0, 3'd1);
    xfer_word(8'hA5, 1'b0);
    end_frame();
    #1;
    check("par_err_sticky", {31'd0, par_err}, 32'd1);
    check_loc(3'd1, 8'hA5, "loc_par_ok");
`endif

    repeat (3) slot(1'b1, 1'b0, s);
    check("wr_queue_drained", exp_wr_q.size(), 32'd0);
    check("rd_queue_drained", exp_rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
